// File: rtl/gnrl_plru_pkg.sv
// Shared encodings for 4-way tree-PLRU allocation: FSM states, per-set state
// types and the victim/touch helper functions.
package gnrl_plru_pkg;

    // Allocation FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOOK = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // p[0] picks the half, p[1] the leaf in ways 0/1, p[2] the leaf in ways 2/3
    typedef logic [2:0] plru_t;
    typedef logic [3:0] vmask_t;

    // Lowest invalid way wins; only a fully valid set falls back to the tree.
    function automatic logic [1:0] plru_victim(input plru_t p, input vmask_t v);
        logic [1:0] w;
        if (!v[0])      w = 2'd0;
        else if (!v[1]) w = 2'd1;
        else if (!v[2]) w = 2'd2;
        else if (!v[3]) w = 2'd3;
        else if (!p[0]) w = p[1] ? 2'd1 : 2'd0;
        else            w = p[2] ? 2'd3 : 2'd2;
        return w;
    endfunction

    // Point the tree away from the touched way; the other leaf is untouched.
    function automatic plru_t plru_touch(input plru_t p, input logic [1:0] w);
        plru_t n;
        n    = p;
        n[0] = ~w[1];
        if (!w[1]) n[1] = ~w[0];
        else       n[2] = ~w[0];
        return n;
    endfunction

endpackage

// File: rtl/plru4_tree_logic.sv
// Combinational 4-way PLRU tree: victim selection for one set and the
// tree bits that result from touching a given way.
module plru4_tree_logic
    import gnrl_plru_pkg::*;
(
    input  plru_t      p,
    input  vmask_t     v,
    input  logic [1:0] way,
    output logic [1:0] vict_way,
    output plru_t      p_nxt
);

    assign vict_way = plru_victim(p, v);
    assign p_nxt    = plru_touch(p, way);

endmodule

// File: rtl/plru4_alloc_ctrl.sv
// Miss allocation controller for a 4-way set-associative cache with
// tree-PLRU replacement. A miss is latched, the victim is chosen one cycle
// later from the set's current state, and held until the refill is acked.
module plru4_alloc_ctrl
    import gnrl_plru_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int SET_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_hit_vld,
    input  logic [SET_W-1:0] i_hit_set,
    input  logic [1:0]       i_hit_way,
    input  logic             i_miss_vld,
    input  logic [SET_W-1:0] i_miss_set,
    output logic             o_miss_rdy,
    output logic             o_vict_vld,
    output logic [SET_W-1:0] o_vict_set,
    output logic [1:0]       o_vict_way,
    input  logic             i_vict_ack,
    input  logic             i_inv_vld,
    input  logic [SET_W-1:0] i_inv_set,
    input  logic [1:0]       i_inv_way,
    input  logic             i_flush
);

    logic [1:0]       state_q;
    logic             rdy_q;
    logic [SET_W-1:0] set_q;
    logic [1:0]       vict_way_q;

    plru_t  p_q [SETS];
    vmask_t v_q [SETS];
    plru_t  p_n [SETS];
    vmask_t v_n [SETS];

    logic       miss_fire;
    logic       ack_fire;
    logic [1:0] look_vict;
    plru_t      ack_p;

    assign miss_fire = i_miss_vld & rdy_q;
    assign ack_fire  = (state_q == ST_WAIT) & i_vict_ack;

    // The latched set serves both the LOOK victim pick and the ack touch,
    // since the set register does not move between LOOK and the ack.
    plru4_tree_logic u_tree (
        .p        (p_q[set_q]),
        .v        (v_q[set_q]),
        .way      (vict_way_q),
        .vict_way (look_vict),
        .p_nxt    (ack_p)
    );

    // Per-set next state: ack fill+touch first, then hit touch, then invalidate.
    always_comb begin
        for (int s = 0; s < SETS; s++) begin
            p_n[s] = p_q[s];
            v_n[s] = v_q[s];
            if (ack_fire && set_q == SET_W'(s)) begin
                v_n[s][vict_way_q] = 1'b1;
                p_n[s]             = ack_p;
            end
            // A hit on a way that is not valid carries no recency information.
            if (i_hit_vld && i_hit_set == SET_W'(s) && v_n[s][i_hit_way])
                p_n[s] = plru_touch(p_n[s], i_hit_way);
            if (i_inv_vld && i_inv_set == SET_W'(s))
                v_n[s][i_inv_way] = 1'b0;
        end
    end

    // Per-set state array; flush and reset both wipe it.
    always_ff @(posedge clk) begin
        for (int s = 0; s < SETS; s++) begin
            if (!rst_n || i_flush) begin
                p_q[s] <= '0;
                v_q[s] <= '0;
            end else begin
                p_q[s] <= p_n[s];
                v_q[s] <= v_n[s];
            end
        end
    end

    // Allocation FSM and held victim; ready is registered so it stays low in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rdy_q      <= 1'b0;
            set_q      <= '0;
            vict_way_q <= '0;
        end else if (i_flush) begin
            state_q    <= ST_IDLE;
            rdy_q      <= 1'b1;
            set_q      <= '0;
            vict_way_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rdy_q <= 1'b1;
                    if (miss_fire) begin
                        set_q   <= i_miss_set;
                        state_q <= ST_LOOK;
                        rdy_q   <= 1'b0;
                    end
                end
                ST_LOOK: begin
                    vict_way_q <= look_vict;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_vict_ack) begin
                        state_q <= ST_IDLE;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign o_miss_rdy = rdy_q;
    assign o_vict_vld = (state_q == ST_WAIT);
    assign o_vict_set = set_q;
    assign o_vict_way = vict_way_q;

endmodule

// File: tb/tb_plru4_alloc_ctrl.sv
// Directed bench for plru4_alloc_ctrl; expected victims are hand-derived
// from the PLRU tree rules for each scenario.
module tb_plru4_alloc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_hit_vld;
    logic [3:0] i_hit_set;
    logic [1:0] i_hit_way;
    logic       i_miss_vld;
    logic [3:0] i_miss_set;
    logic       o_miss_rdy;
    logic       o_vict_vld;
    logic [3:0] o_vict_set;
    logic [1:0] o_vict_way;
    logic       i_vict_ack;
    logic       i_inv_vld;
    logic [3:0] i_inv_set;
    logic [1:0] i_inv_way;
    logic       i_flush;

    int n_chk  = 0;
    int n_fail = 0;

    plru4_alloc_ctrl #(.SETS(16), .SET_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_hit_vld  (i_hit_vld),
        .i_hit_set  (i_hit_set),
        .i_hit_way  (i_hit_way),
        .i_miss_vld (i_miss_vld),
        .i_miss_set (i_miss_set),
        .o_miss_rdy (o_miss_rdy),
        .o_vict_vld (o_vict_vld),
        .o_vict_set (o_vict_set),
        .o_vict_way (o_vict_way),
        .i_vict_ack (i_vict_ack),
        .i_inv_vld  (i_inv_vld),
        .i_inv_set  (i_inv_set),
        .i_inv_way  (i_inv_way),
        .i_flush    (i_flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy;
        int k = 0;
        while (o_miss_rdy !== 1'b1 && k < 20) begin
            tick;
            k++;
        end
        if (o_miss_rdy !== 1'b1) chk("rdy_timeout", {31'd0, o_miss_rdy}, 32'd1);
    endtask

    // Accept a miss, confirm LOOK (no valid yet), then check the held victim.
    task automatic miss(input logic [3:0] s, input logic [1:0] w, input string tag);
        wait_rdy;
        i_miss_vld = 1'b1;
        i_miss_set = s;
        tick;
        i_miss_vld = 1'b0;
        chk({tag, "_look_vld"}, {31'd0, o_vict_vld}, 32'd0);
        tick;
        chk({tag, "_vld"}, {31'd0, o_vict_vld}, 32'd1);
        chk({tag, "_set"}, {28'd0, o_vict_set}, {28'd0, s});
        chk({tag, "_way"}, {30'd0, o_vict_way}, {30'd0, w});
    endtask

    task automatic ack(input string tag);
        i_vict_ack = 1'b1;
        tick;
        i_vict_ack = 1'b0;
        chk({tag, "_ack_vld"}, {31'd0, o_vict_vld}, 32'd0);
        chk({tag, "_ack_rdy"}, {31'd0, o_miss_rdy}, 32'd1);
    endtask

    // Fill an empty set: victims 0..3 in order, tree ends at p=000.
    task automatic fill(input logic [3:0] s, input string tag);
        for (int w = 0; w < 4; w++) begin
            miss(s, 2'(w), tag);
            ack(tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        i_hit_vld  = 1'b0;
        i_hit_set  = '0;
        i_hit_way  = '0;
        i_miss_vld = 1'b0;
        i_miss_set = '0;
        i_vict_ack = 1'b0;
        i_inv_vld  = 1'b0;
        i_inv_set  = '0;
        i_inv_way  = '0;
        i_flush    = 1'b0;

        // Reset values
        repeat (3) tick;
        chk("rst_rdy", {31'd0, o_miss_rdy}, 32'd0);
        chk("rst_vld", {31'd0, o_vict_vld}, 32'd0);
        chk("rst_set", {28'd0, o_vict_set}, 32'd0);
        chk("rst_way", {30'd0, o_vict_way}, 32'd0);
        rst_n = 1'b1;
        tick;
        chk("post_rst_rdy", {31'd0, o_miss_rdy}, 32'd1);

        // Empty set 3 -> way0; ack in IDLE is ignored; next victim way1
        miss(4'd3, 2'd0, "s3a");
        ack("s3a");
        i_vict_ack = 1'b1;
        tick;
        i_vict_ack = 1'b0;
        chk("idle_ack_vld", {31'd0, o_vict_vld}, 32'd0);
        miss(4'd3, 2'd1, "s3b");
        ack("s3b");

        // Set 5: fill, then PLRU victim way0 (p=000); after its ack p=011
        fill(4'd5, "s5");
        miss(4'd5, 2'd0, "s5_plru");
        ack("s5_plru");

        // Set 7 full p=000; hit way0 in the accept cycle -> p=011 -> way2
        fill(4'd7, "s7");
        wait_rdy;
        i_miss_vld = 1'b1;
        i_miss_set = 4'd7;
        i_hit_vld  = 1'b1;
        i_hit_set  = 4'd7;
        i_hit_way  = 2'd0;
        tick;
        i_miss_vld = 1'b0;
        i_hit_vld  = 1'b0;
        tick;
        chk("s7_hit_vld", {31'd0, o_vict_vld}, 32'd1);
        chk("s7_hit_way", {30'd0, o_vict_way}, 32'd2);
        ack("s7_hit");

        // Set 2 full; invalidate way1 while waiting; held victim stays way0
        fill(4'd2, "s2");
        miss(4'd2, 2'd0, "s2_inv");
        i_inv_vld = 1'b1;
        i_inv_set = 4'd2;
        i_inv_way = 2'd1;
        tick;
        i_inv_vld = 1'b0;
        chk("s2_inv_hold_vld", {31'd0, o_vict_vld}, 32'd1);
        chk("s2_inv_hold_way", {30'd0, o_vict_way}, 32'd0);
        ack("s2_inv");
        miss(4'd2, 2'd1, "s2_refill");
        ack("s2_refill");

        // Set 9: ack way3 with hit way1 same cycle. Ack touch gives p=000,
        // hit touch then gives p0=1,p1=0,p2=0, so the full set picks way2.
        miss(4'd9, 2'd0, "s9a");
        ack("s9a");
        miss(4'd9, 2'd1, "s9b");
        ack("s9b");
        miss(4'd9, 2'd2, "s9c");
        ack("s9c");
        miss(4'd9, 2'd3, "s9d");
        i_hit_vld = 1'b1;
        i_hit_set = 4'd9;
        i_hit_way = 2'd1;
        ack("s9d");
        i_hit_vld = 1'b0;
        miss(4'd9, 2'd2, "s9_order");
        ack("s9_order");

        // Set 11: inv and ack on the same way -> stays invalid -> way0 again
        miss(4'd11, 2'd0, "s11a");
        i_inv_vld = 1'b1;
        i_inv_set = 4'd11;
        i_inv_way = 2'd0;
        ack("s11a");
        i_inv_vld = 1'b0;
        miss(4'd11, 2'd0, "s11b");
        ack("s11b");

        // Set 5 full with p=011 -> way2; flush while waiting
        miss(4'd5, 2'd2, "s5_preflush");
        i_flush = 1'b1;
        tick;
        i_flush = 1'b0;
        chk("flush_vld", {31'd0, o_vict_vld}, 32'd0);
        chk("flush_rdy", {31'd0, o_miss_rdy}, 32'd1);
        miss(4'd5, 2'd0, "flush_s5");
        ack("flush_s5");
        miss(4'd7, 2'd0, "flush_s7");
        ack("flush_s7");
        miss(4'd9, 2'd0, "flush_s9");
        ack("flush_s9");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
